arb_mux: RTL and testbench
==========================

# arb_mux

Parametrised N-way, WIDTH-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every input and on the output. It is the sequential successor to the fixed byte-wide 2/4/8-to-1 muxes in the ALU datapath. It supports two modes: round-robin arbitration among requesting channels, or a steered fixed select. It sits between multiple producers, such as register-file read ports or ALU result sources, and a single consumer.

## Interface
- WIDTH, 8, data width of each channel in bits (≥1)
- N, 4, number of input channels (≥2; need not be a power of two)
- SEL_W, $clog2(N), width of select and source-ID fields (derived, not overridden)

- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  reset, synchronous and active-low
- mode  input  1  0 = round-robin arbitration, 1 = fixed select
- sel  input  SEL_W  channel index used when mode = 1
- in_valid  input  N  per-channel request
- in_data  input  N×WIDTH  packed channel data; channel i occupies in_data[i]
- in_ready  output  N  per-channel accept; at most one bit high per cycle
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered data
- out_src  output  SEL_W  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts the beat

## Operation
- Transfer on channel i occurs when in_valid[i] & in_ready[i]. The output transfer occurs when out_valid & out_ready.
- can_load = ~out_valid | out_ready. The output register accepts a new beat when it is empty or draining in the same cycle.
- Grant logic is combinational and produces a one-hot grant[N]:
  - Round-robin (mode = 0): the first requesting channel at or after ptr, searching upward and wrapping from N-1 to 0.
  - Fixed (mode = 1): grant[sel] = in_valid[sel]. If sel ≥ N, no grant is issued.
- in_ready[i] = grant[i] & can_load. in_ready depends combinationally on in_valid, mode, sel, ptr and out_ready. Producers must not make in_valid depend on in_ready.
- On an input transfer from channel g, the block loads out_data ← in_data[g] and out_src ← g, and sets out_valid to 1.
- In round-robin mode, an input transfer from channel g sets ptr ← (g+1) mod N. In fixed mode, ptr is unchanged.
- If the output drains with no new input transfer, out_valid ← 0. out_data and out_src hold their last value.
- If a drain and a load happen in the same cycle, the load wins: out_valid stays 1 and the new beat is presented. Sustained throughput is one beat per cycle.
- While out_valid & ~out_ready, out_data and out_src are stable. No in_ready is asserted.
- Changes to mode or sel affect only the next grant. A beat already held in the output register is unaffected.
- Withdrawing in_valid without a transfer is permitted. The withdrawn channel simply is not granted.

## Timing
- Latency is 1 cycle: a beat accepted at edge k appears on out_data/out_valid after edge k.
- Reset (rst_n = 0 at a rising edge) sets out_valid = 0, out_data = 0, out_src = 0 and ptr = 0.
- While rst_n = 0, in_ready is forced to all zeros.
- Reset asserted mid-operation discards any held beat. No partial transfer is reported.
- Round-robin fairness: with all N channels requesting continuously and out_ready = 1, each channel is granted exactly once every N cycles.
- No combinational path runs from any input to out_valid, out_data or out_src.

## Structure
- Package mux_pkg holds the mode encodings MODE_RR = 1'b0 and MODE_FIXED = 1'b1.
- Package mux_pkg also holds a function next_ptr(g, N) implementing the wraparound increment.
- Sub-module rr_grant is parametrised by N. It takes req[N] and ptr, and outputs a one-hot grant[N] plus its encoded index. It is purely combinational and is reused by future arbiters.
- Top level contains the mode/sel override, the in_ready gating, the ptr register and the output register.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with all in_valid = 1 -> in_ready = 0 and out_valid = 0. First grant after release goes to channel 0.
- Round-robin fairness: N = 4, WIDTH = 8, in_data = {8'hA0, 8'hA1, 8'hA2, 8'hA3}, all valid, out_ready = 1 -> out_src sequence 0,1,2,3,0 with matching data on consecutive cycles.
- Backpressure: beat 8'h5A held with out_ready = 0 for 3 cycles -> out_data stays 8'h5A, in_ready = 0. When out_ready rises, a new beat loads in the same cycle with no bubble.
- Fixed mode: mode = 1, sel = 2, channels 0–3 all valid -> only channel 2 is ever granted. With sel = 3 and in_valid[3] = 0, no grant is issued and out_valid drops after the drain.
- Skip and wrap: ptr = 3, only channels 1 and 3 valid -> grant order 3,1,3,1. With N = 3 (non-power-of-two) and sel = 3 in fixed mode -> no grant.
- Reset mid-stream: assert rst_n = 0 while out_valid = 1 -> out_valid = 0 and out_data = 0 next cycle, and ptr restarts at 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrating mux: mode encodings and the
// round-robin pointer wraparound helper.
package mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;

  // Increment a channel index, wrapping from n-1 back to 0.
  function automatic int unsigned next_ptr(input int unsigned g, input int unsigned n);
    return (g + 32'd1 >= n) ? 32'd0 : g + 32'd1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: first requester at or after ptr,
// searching upward with wraparound; one-hot grant plus encoded index.
module rr_grant #(
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [SEL_W-1:0] grant_idx_c
);

  int unsigned cand;
  logic        found;

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    cand        = 32'd0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr < N and k < N, so a single conditional subtract wraps correctly
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[SEL_W'(cand)]) begin
        found                   = 1'b1;
        grant_c[SEL_W'(cand)]   = 1'b1;
        grant_idx_c             = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-way arbitrating mux with a registered output stage and valid/ready
// handshakes; round-robin or steered fixed-select arbitration.
module arb_mux
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N-1:0]            in_valid,
  input  logic [N-1:0][WIDTH-1:0] in_data,
  output logic [N-1:0]            in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;

  logic [N-1:0]     rr_grant_c;
  logic [SEL_W-1:0] rr_idx_c;
  logic [N-1:0]     grant_c;
  logic [SEL_W-1:0] grant_idx_c;
  logic             can_load_c;
  logic             load_c;

  rr_grant #(.N(N)) u_rr_grant (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant_c     (rr_grant_c),
    .grant_idx_c (rr_idx_c)
  );

  // Mode override, ready gating and next-state for pointer and output register
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    if (mode_e'(mode) == MODE_FIXED) begin
      if (32'(sel) < N) begin
        grant_c[sel] = in_valid[sel];
        grant_idx_c  = sel;
      end
    end else begin
      grant_c     = rr_grant_c;
      grant_idx_c = rr_idx_c;
    end

    can_load_c = ~out_valid_q | out_ready;
    in_ready   = rst_n ? (grant_c & {N{can_load_c}}) : '0;
    load_c     = |in_ready;

    ptr_d       = ptr_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load_c) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant_idx_c];
      out_src_d   = grant_idx_c;
      if (mode_e'(mode) == MODE_RR) ptr_d = SEL_W'(next_ptr(32'(grant_idx_c), N));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: vector table for arbitration sequences plus
// hand-written reset, backpressure and non-power-of-two cases.
module tb_arb_mux;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic [1:0]       sel;
  logic [3:0]       in_valid;
  logic [3:0][7:0]  in_data;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  logic             mode3;
  logic [1:0]       sel3;
  logic [2:0]       in_valid3;
  logic [2:0][7:0]  in_data3;
  logic [2:0]       in_ready3;
  logic             out_valid3;
  logic [7:0]       out_data3;
  logic [1:0]       out_src3;
  logic             out_ready3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(8), .N(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(8), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_src(out_src3),
    .out_ready(out_ready3)
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_data;
    logic [1:0] exp_src;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // mode sel valid ordy | rdy ov data src
    vecs[0]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[1]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[2]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[3]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    vecs[4]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[5]  = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
    vecs[6]  = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
    vecs[7]  = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0};
    vecs[8]  = '{1'b0, 2'd0, 4'h4, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[9]  = '{1'b0, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    vecs[10] = '{1'b0, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[11] = '{1'b0, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    vecs[12] = '{1'b0, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[13] = '{1'b1, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[14] = '{1'b1, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[15] = '{1'b1, 2'd3, 4'h7, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2};
    vecs[16] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[17] = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
    vecs[18] = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};

    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'hF;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;
    mode3      = 1'b0;
    sel3       = 2'd0;
    in_valid3  = 3'b000;
    in_data3   = {8'hC2, 8'hC1, 8'hC0};
    out_ready3 = 1'b1;

    repeat (2) begin
      tick();
      chk("reset_in_ready", 32'(in_ready), 32'h0);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].valid;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_out_src", i), 32'(out_src), 32'(vecs[i].exp_src));
    end

    // Backpressure: 5A held for 3 cycles, then replaced with no bubble
    mode = 1'b1; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
    in_data[1] = 8'h5A;
    #1;
    chk("bp_load_rdy", 32'(in_ready), 32'b0010);
    tick();
    chk("bp_load_data", 32'(out_data), 32'h5A);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_hold_rdy", 32'(in_ready), 32'h0);
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_hold_data", 32'(out_data), 32'h5A);
    end
    in_data[1] = 8'h5B;
    out_ready  = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'b0010);
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'h1);
    chk("bp_release_data", 32'(out_data), 32'h5B);
    chk("bp_release_src", 32'(out_src), 32'h1);

    // Reset while a beat is held
    rst_n = 1'b0; mode = 1'b0; in_valid = 4'hF; out_ready = 1'b0;
    #1;
    chk("midrst_rdy", 32'(in_ready), 32'h0);
    tick();
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_data", 32'(out_data), 32'h0);
    chk("midrst_src", 32'(out_src), 32'h0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("midrst_first_rdy", 32'(in_ready), 32'b0001);
    tick();
    chk("midrst_first_data", 32'(out_data), 32'hA0);
    chk("midrst_first_src", 32'(out_src), 32'h0);

    // N = 3: round-robin wraps 2 -> 0, fixed sel = 3 grants nothing
    in_valid3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("n3_rr_rdy", 32'(in_ready3), 32'(3'b001 << (c % 3)));
      tick();
      chk("n3_rr_src", 32'(out_src3), 32'(c % 3));
      chk("n3_rr_data", 32'(out_data3), 32'(8'hC0 + 8'(c % 3)));
    end
    mode3 = 1'b1; sel3 = 2'd3;
    #1;
    chk("n3_sel_oob_rdy", 32'(in_ready3), 32'h0);
    tick();
    chk("n3_sel_oob_valid", 32'(out_valid3), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
